// File: rtl/av1_symbol_decoder.sv
// AV1 multi-symbol arithmetic decoder: refills a 32-bit dif window from the
// byte stream and resolves one symbol per request against a caller-held icdf.
module av1_symbol_decoder #(
  parameter int MAX_SYMS  = 16,
  parameter int CDF_WIDTH = 16,
  parameter int WINDOW    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  input  logic [7:0]           byte_data,
  input  logic                 byte_last,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [4:0]           req_nsyms,
  output logic [3:0]           cdf_idx,
  input  logic [CDF_WIDTH-1:0] cdf_icdf,
  output logic                 sym_valid,
  input  logic                 sym_ready,
  output logic [3:0]           sym_data
);

  typedef enum logic [2:0] {IDLE, REFILL, READY, SEARCH, UPDATE, OUT} state_t;

  state_t state, next_state;

  logic [15:0]        rng;
  logic [WINDOW-1:0]  dif;
  logic signed [7:0]  cnt;
  logic               ended;
  logic               ret_to_out;
  logic [3:0]         nmax;
  logic [3:0]         ret;
  logic [17:0]        u;
  logic [17:0]        u_sel;
  logic [17:0]        v_sel;
  logic [3:0]         sym;

  logic signed [7:0]  shift;
  logic               need_byte;
  logic [15:0]        c;
  logic [23:0]        prod;
  logic [17:0]        v;
  logic               take_sym;
  logic [17:0]        r;
  logic [3:0]         msb;
  logic [3:0]         d;
  logic [15:0]        rng_norm;
  logic [WINDOW-1:0]  dif_sub;
  logic [WINDOW-1:0]  dif_norm;
  logic signed [7:0]  cnt_upd;
  logic               nsyms_ok;

  // Bit position at which the next byte lands; negative once the window is full.
  assign shift     = 8'(WINDOW - 24) - cnt;
  assign need_byte = !shift[7];
  assign c         = dif[WINDOW-1 -: 16];
  assign nsyms_ok  = (req_nsyms >= 5'd2) && (req_nsyms <= 5'(MAX_SYMS));

  always_comb begin
    prod = 24'(rng[15:8]) * 24'(cdf_icdf >> 6);
    v    = '0;
    if (ret != nmax)
      v = 18'(prod >> 1) + 18'({(nmax - ret), 2'b00});
    take_sym = !({2'b00, c} < v);
  end

  // Renormalisation: shift r back up to a 16-bit range with MSB at bit 15.
  always_comb begin
    r   = u_sel - v_sel;
    msb = '0;
    for (int unsigned i = 0; i < 16; i++)
      if (r[i]) msb = 4'(i);
    d        = 4'd15 - msb;
    rng_norm = 16'(r << d);
    dif_sub  = dif - (WINDOW'(v_sel) << 16);
    dif_norm = ((dif_sub + WINDOW'(1)) << d) - WINDOW'(1);
    cnt_upd  = cnt - 8'(d);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (start) begin
      next_state = REFILL;
    end else begin
      case (state)
        IDLE:    next_state = IDLE;
        REFILL:  if (!need_byte) next_state = ret_to_out ? OUT : READY;
        READY:   if (req_valid) next_state = SEARCH;
        SEARCH:  if (take_sym) next_state = UPDATE;
        UPDATE:  next_state = cnt_upd[7] ? REFILL : OUT;
        OUT:     if (sym_ready) next_state = READY;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    byte_ready = (state == REFILL) && need_byte && !ended && !start;
    req_ready  = (state == READY) && !start;
    sym_valid  = (state == OUT) && !start;
    cdf_idx    = ret;
    sym_data   = sym;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rng        <= 16'h8000;
      dif        <= {1'b0, {(WINDOW-1){1'b1}}};
      cnt        <= -8'sd15;
      ended      <= 1'b0;
      ret_to_out <= 1'b0;
      nmax       <= '0;
      ret        <= '0;
      u          <= '0;
      u_sel      <= '0;
      v_sel      <= '0;
      sym        <= '0;
    end else if (start) begin
      rng        <= 16'h8000;
      dif        <= {1'b0, {(WINDOW-1){1'b1}}};
      cnt        <= -8'sd15;
      ended      <= 1'b0;
      ret_to_out <= 1'b0;
    end else begin
      case (state)
        REFILL: begin
          // After the last byte, zero bytes are implied without a handshake.
          if (need_byte) begin
            if (ended) begin
              cnt <= cnt + 8'sd8;
            end else if (byte_valid) begin
              dif <= dif ^ (WINDOW'(byte_data) << shift);
              cnt <= cnt + 8'sd8;
              if (byte_last) ended <= 1'b1;
            end
          end
        end
        READY: begin
          if (req_valid) begin
            nmax <= nsyms_ok ? 4'(req_nsyms - 5'd1) : 4'(MAX_SYMS - 1);
            ret  <= '0;
            u    <= {2'b00, rng};
          end
        end
        SEARCH: begin
          if (take_sym) begin
            sym   <= ret;
            v_sel <= v;
            u_sel <= u;
          end else begin
            u   <= v;
            ret <= ret + 4'd1;
          end
        end
        UPDATE: begin
          rng        <= rng_norm;
          dif        <= dif_norm;
          cnt        <= cnt_upd;
          ret_to_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_av1_symbol_decoder.sv
// Directed bench for av1_symbol_decoder with hand-derived arithmetic results.
module tb_av1_symbol_decoder;

  logic        clk = 1'b0;
  logic        reset, start, byte_valid, byte_last, req_valid, sym_ready;
  logic [7:0]  byte_data;
  logic [4:0]  req_nsyms;
  logic        byte_ready, req_ready, sym_valid;
  logic [3:0]  cdf_idx, sym_data;
  logic [15:0] cdf_icdf;
  logic [15:0] icdf_tab [16];

  int checks = 0;
  int errors = 0;
  int hs_total = 0;
  int cyc, hs_mark;
  logic [31:0] seq;

  always #5 clk = ~clk;

  assign cdf_icdf = icdf_tab[cdf_idx];

  always @(posedge clk)
    if (byte_valid && byte_ready) hs_total <= hs_total + 1;

  av1_symbol_decoder #(.MAX_SYMS(16), .CDF_WIDTH(16), .WINDOW(32)) dut (
    .clk(clk), .reset(reset), .start(start),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
    .byte_last(byte_last), .req_valid(req_valid), .req_ready(req_ready),
    .req_nsyms(req_nsyms), .cdf_idx(cdf_idx), .cdf_icdf(cdf_icdf),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_data(sym_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_icdf_all(input logic [15:0] val);
    for (int i = 0; i < 16; i++) icdf_tab[i] = val;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    n = 0;
    byte_valid = 1'b1; byte_data = b; byte_last = last;
    #1;
    while (!byte_ready && n < 40) begin tick(); n++; end
    chk("byte_accept", 32'(byte_ready), 32'd1);
    tick();
    byte_valid = 1'b0; byte_last = 1'b0;
  endtask

  task automatic wait_req_ready();
    int n;
    n = 0;
    while (!req_ready && n < 64) begin tick(); n++; end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic request(input logic [4:0] n);
    req_valid = 1'b1; req_nsyms = n;
    #1;
    wait_req_ready();
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_sym(output int c, output logic [31:0] s);
    c = 0; s = '0;
    while (!sym_valid && c < 100) begin
      s = {s[27:0], cdf_idx};
      tick();
      c++;
    end
    chk("sym_valid_wait", 32'(sym_valid), 32'd1);
  endtask

  task automatic accept();
    sym_ready = 1'b1;
    tick();
    sym_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0;
    byte_data = '0; req_valid = 1'b0; req_nsyms = '0; sym_ready = 1'b0;
    set_icdf_all(16'h0000);
    tick(); tick(); tick();
    chk("rst_byte_ready", 32'(byte_ready), 32'd0);
    chk("rst_req_ready",  32'(req_ready),  32'd0);
    chk("rst_sym_valid",  32'(sym_valid),  32'd0);
    chk("rst_cdf_idx",    32'(cdf_idx),    32'd0);
    chk("rst_sym_data",   32'(sym_data),   32'd0);
    chk("rst_rng",        32'(dut.rng),    32'h8000);
    chk("rst_dif",        dut.dif,         32'h7FFF_FFFF);
    chk("rst_cnt",        32'(int'(dut.cnt)), -32'sd15);
    reset = 1'b0;

    // requests before init are ignored
    req_valid = 1'b1; req_nsyms = 5'd2;
    tick(); tick();
    chk("idle_req_ready", 32'(req_ready), 32'd0);
    chk("idle_rng",       32'(dut.rng),   32'h8000);
    req_valid = 1'b0;

    // tile 1: zero bytes, binary decode
    hs_mark = hs_total;
    do_start();
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    wait_req_ready();
    chk("t1_hs",  32'(hs_total - hs_mark), 32'd3);
    chk("t1_dif", dut.dif, 32'h7FFF_FFFF);
    chk("t1_cnt", 32'(int'(dut.cnt)), 32'd9);
    chk("t1_rng", 32'(dut.rng), 32'h8000);
    icdf_tab[0] = 16'd16384;
    request(5'd2);
    wait_sym(cyc, seq);
    chk("t1_cyc",  32'(cyc), 32'd2);
    chk("t1_sym",  32'(sym_data), 32'd0);
    chk("t1_rng2", 32'(dut.rng), 32'hFFF0);
    chk("t1_dif2", dut.dif, 32'hFFEF_FFFF);
    chk("t1_cnt2", 32'(int'(dut.cnt)), 32'd7);
    accept();
    chk("t1_ready_after", 32'(req_ready), 32'd1);

    // tile 2: FF bytes, 4-ary decode walking the whole table
    do_start();
    send_byte(8'hFF, 1'b0); send_byte(8'hFF, 1'b0); send_byte(8'hFF, 1'b0);
    wait_req_ready();
    chk("t2_dif", dut.dif, 32'h0000_007F);
    chk("t2_cnt", 32'(int'(dut.cnt)), 32'd9);
    icdf_tab[0] = 16'd24576; icdf_tab[1] = 16'd16384; icdf_tab[2] = 16'd8192;
    request(5'd4);
    wait_sym(cyc, seq);
    chk("t2_cyc",  32'(cyc), 32'd5);
    chk("t2_idx_seq", seq, 32'h0000_1233);
    chk("t2_sym",  32'(sym_data), 32'd3);
    chk("t2_rng2", 32'(dut.rng), 32'h8010);
    chk("t2_dif2", dut.dif, 32'h0000_01FF);
    chk("t2_cnt2", 32'(int'(dut.cnt)), 32'd7);
    for (int i = 0; i < 4; i++) begin
      chk("hold_sym_valid", 32'(sym_valid), 32'd1);
      chk("hold_sym_data",  32'(sym_data),  32'd3);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    accept();
    chk("t2_ready_after", 32'(req_ready), 32'd1);

    // large renormalisation forces a refill; stall it for 5 cycles
    set_icdf_all(16'h0000);
    hs_mark = hs_total;
    request(5'd2);
    for (int n = 0; n < 40 && !byte_ready; n++) tick();
    chk("t3_in_refill", 32'(byte_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_cnt", 32'(int'(dut.cnt)), -32'sd6);
      chk("stall_dif", dut.dif, 32'h003F_FFFF);
      chk("stall_sym_valid", 32'(sym_valid), 32'd0);
      tick();
    end
    send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0);
    wait_sym(cyc, seq);
    chk("t3_hs",  32'(hs_total - hs_mark), 32'd2);
    chk("t3_sym", 32'(sym_data), 32'd1);
    chk("t3_dif", dut.dif, 32'h003B_72FF);
    chk("t3_cnt", 32'(int'(dut.cnt)), 32'd10);
    chk("t3_rng", 32'(dut.rng), 32'h8000);
    accept();

    // tile 4: last byte on the second byte, third byte implied
    hs_mark = hs_total;
    do_start();
    send_byte(8'hFF, 1'b0); send_byte(8'hFF, 1'b1);
    wait_req_ready();
    chk("t4_hs",    32'(hs_total - hs_mark), 32'd2);
    chk("t4_dif",   dut.dif, 32'h0000_7FFF);
    chk("t4_cnt",   32'(int'(dut.cnt)), 32'd9);
    chk("t4_ended", 32'(dut.ended), 32'd1);
    byte_valid = 1'b1; byte_data = 8'hA5; byte_last = 1'b0;
    hs_mark = hs_total;
    request(5'd2);
    wait_sym(cyc, seq);
    chk("t4_cyc",  32'(cyc), 32'd6);
    chk("t4_hs2",  32'(hs_total - hs_mark), 32'd0);
    chk("t4_sym",  32'(sym_data), 32'd1);
    chk("t4_dif2", dut.dif, 32'h0FFF_FFFF);
    chk("t4_cnt2", 32'(int'(dut.cnt)), 32'd12);
    byte_valid = 1'b0;

    // start while a symbol is pending discards it
    start = 1'b1;
    #1;
    chk("start_out_sym_valid",  32'(sym_valid),  32'd0);
    chk("start_out_byte_ready", 32'(byte_ready), 32'd0);
    tick();
    start = 1'b0;

    // tile 5: out-of-range nsyms decodes as a 16-symbol alphabet
    hs_mark = hs_total;
    send_byte(8'hFF, 1'b0); send_byte(8'hFF, 1'b0); send_byte(8'hFF, 1'b0);
    wait_req_ready();
    chk("t5_hs",    32'(hs_total - hs_mark), 32'd3);
    chk("t5_ended", 32'(dut.ended), 32'd0);
    chk("t5_dif",   dut.dif, 32'h0000_007F);
    set_icdf_all(16'h0000);
    byte_valid = 1'b1; byte_data = 8'h00; byte_last = 1'b0;
    hs_mark = hs_total;
    request(5'd1);
    wait_sym(cyc, seq);
    byte_valid = 1'b0;
    chk("t5_cyc",  32'(cyc), 32'd20);
    chk("t5_sym",  32'(sym_data), 32'd15);
    chk("t5_hs2",  32'(hs_total - hs_mark), 32'd2);
    chk("t5_dif2", dut.dif, 32'h000F_FFFF);
    chk("t5_cnt2", 32'(int'(dut.cnt)), 32'd12);
    chk("t5_rng2", 32'(dut.rng), 32'h8000);
    accept();

    // reset during SEARCH
    do_start();
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    wait_req_ready();
    set_icdf_all(16'hFFFF);
    request(5'd16);
    tick(); tick();
    chk("search_idx", 32'(cdf_idx), 32'd2);
    reset = 1'b1;
    tick();
    chk("mid_rst_sym_valid",  32'(sym_valid),  32'd0);
    chk("mid_rst_req_ready",  32'(req_ready),  32'd0);
    chk("mid_rst_byte_ready", 32'(byte_ready), 32'd0);
    chk("mid_rst_cdf_idx",    32'(cdf_idx),    32'd0);
    chk("mid_rst_sym_data",   32'(sym_data),   32'd0);
    chk("mid_rst_rng",        32'(dut.rng),    32'h8000);
    chk("mid_rst_dif",        dut.dif,         32'h7FFF_FFFF);
    chk("mid_rst_cnt",        32'(int'(dut.cnt)), -32'sd15);
    reset = 1'b0;
    tick(); tick();
    chk("post_rst_sym_valid", 32'(sym_valid), 32'd0);
    chk("post_rst_req_ready", 32'(req_ready), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
